// File: rtl/dram_pkg.sv
// rtl/dram_pkg.sv - shared constants, state encoding and lane types for the DRAM batcher
//
// Purpose: lane geometry, the DRAM latency the issue gap is derived from, the
// batcher state encoding, lane typedefs and a helper that turns a lane count
// into a contiguous lane mask.
package dram_pkg;

  localparam int NUM_LANES        = 8;
  localparam int ADDR_W           = 64;
  localparam int DATA_W           = 8;
  localparam int DRAM_WAIT_CYCLES = 20;
  localparam int LANE_IDX_W       = $clog2(NUM_LANES);
  localparam int CNT_W            = LANE_IDX_W + 1;

  typedef enum logic [2:0] {
    COLLECT = 3'd0,
    ISSUE   = 3'd1,
    WAIT_RD = 3'd2,
    WAIT_WR = 3'd3,
    DRAIN   = 3'd4
  } state_e;

  typedef logic [ADDR_W-1:0]     addr_t;
  typedef logic [DATA_W-1:0]     data_t;
  typedef logic [CNT_W-1:0]      cnt_t;
  typedef logic [LANE_IDX_W-1:0] lane_idx_t;
  typedef addr_t [NUM_LANES-1:0] lane_addr_t;
  typedef data_t [NUM_LANES-1:0] lane_data_t;

  // Lanes 0..n-1 set; n == NUM_LANES gives all ones.
  function automatic logic [NUM_LANES-1:0] count_mask(input cnt_t n);
    logic [NUM_LANES-1:0] m;
    for (int i = 0; i < NUM_LANES; i++) m[i] = (CNT_W'(i) < n);
    return m;
  endfunction

endpackage

// File: rtl/dram_batcher_if.sv
// rtl/dram_batcher_if.sv - client-side request/response bundle of the DRAM batcher
//
// Purpose: byte-request handshake, flush, read-data handshake and write-commit pulse.
// master: the client (drives req_*, flush, rsp_ready).
// slave : the batcher (drives req_ready, rsp_valid, rsp_data, wr_done).
interface dram_batcher_if;
  import dram_pkg::*;

  logic  req_valid;
  logic  req_ready;
  logic  req_rdwr;
  addr_t req_addr;
  data_t req_wdata;
  logic  flush;
  logic  rsp_valid;
  logic  rsp_ready;
  data_t rsp_data;
  logic  wr_done;

  modport master (
    output req_valid, req_rdwr, req_addr, req_wdata, flush, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, wr_done
  );

  modport slave (
    input  req_valid, req_rdwr, req_addr, req_wdata, flush, rsp_ready,
    output req_ready, rsp_valid, rsp_data, wr_done
  );
endinterface

// File: rtl/dram_lane_buf.sv
// rtl/dram_lane_buf.sv - 8-entry lane storage for one DRAM batch
//
// Purpose: holds address/data per lane.
// Ports: clk; wr_en/wr_idx/wr_addr/wr_data write one lane from a client request;
// ld_mask/ld_data overwrite the data of masked lanes with DRAM read data;
// rd_idx/rd_data read one lane's data; lane_addr/lane_data expose every lane.
module dram_lane_buf
  import dram_pkg::*;
(
  input  logic                 clk,
  input  logic                 wr_en,
  input  lane_idx_t            wr_idx,
  input  addr_t                wr_addr,
  input  data_t                wr_data,
  input  logic [NUM_LANES-1:0] ld_mask,
  input  lane_data_t           ld_data,
  input  lane_idx_t            rd_idx,
  output data_t                rd_data,
  output lane_addr_t           lane_addr,
  output lane_data_t           lane_data
);

  lane_addr_t addr_q;
  lane_data_t data_q;

  // No reset: contents are only meaningful below the batcher's lane count,
  // which reset clears.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      addr_q[wr_idx] <= wr_addr;
      data_q[wr_idx] <= wr_data;
    end
    for (int i = 0; i < NUM_LANES; i++) begin
      if (ld_mask[i]) data_q[i] <= ld_data[i];
    end
  end

  assign rd_data   = data_q[rd_idx];
  assign lane_addr = addr_q;
  assign lane_data = data_q;

endmodule

// File: rtl/dram_batcher.sv
// rtl/dram_batcher.sv - groups client byte requests into 8-lane DRAM batches
//
// Purpose: collects same-type requests into lanes, issues them as one dram_en
// pulse (respecting a minimum issue gap), returns read bytes in request order
// and signals write commit.
// Ports: clk, reset (sync, active-high); cli (dram_batcher_if.slave) client
// side; dram_en/dram_rdwr/dram_addr/dram_data_in to the DRAM;
// dram_data_out/dram_valid from the DRAM.
module dram_batcher
  import dram_pkg::*;
#(
  parameter int FLUSH_TIMEOUT = 8,
  parameter int ISSUE_GAP     = DRAM_WAIT_CYCLES + 2
) (
  input  logic                 clk,
  input  logic                 reset,
  dram_batcher_if.slave        cli,
  output logic [NUM_LANES-1:0] dram_en,
  output logic                 dram_rdwr,
  output lane_addr_t           dram_addr,
  output lane_data_t           dram_data_in,
  input  lane_data_t           dram_data_out,
  input  logic [NUM_LANES-1:0] dram_valid
);

  localparam logic [2:0] S_COLLECT = COLLECT;
  localparam logic [2:0] S_ISSUE   = ISSUE;
  localparam logic [2:0] S_WAIT_RD = WAIT_RD;
  localparam logic [2:0] S_WAIT_WR = WAIT_WR;
  localparam logic [2:0] S_DRAIN   = DRAIN;

  localparam int TW = $clog2(FLUSH_TIMEOUT + 1);
  localparam int GW = $clog2(ISSUE_GAP + 1);
  localparam logic [TW-1:0] TMO_MAX = TW'(FLUSH_TIMEOUT);
  localparam logic [GW-1:0] GAP_MAX = GW'(ISSUE_GAP);
  localparam logic [GW-1:0] WR_LAST = GW'(ISSUE_GAP - 1);
  localparam cnt_t          FULL    = CNT_W'(NUM_LANES);

  logic [2:0]           state_q;
  cnt_t                 count_q;
  logic                 batch_type_q;
  logic [TW-1:0]        tmo_q;
  logic [GW-1:0]        gap_q;
  logic [GW-1:0]        wait_q;
  lane_idx_t            rd_idx_q;

  logic [NUM_LANES-1:0] lane_mask;
  logic                 in_collect, timeout, type_ok, accept, go_issue;
  logic                 gap_ok, issue_fire, rd_cap, wr_fin, rsp_fire, last_rsp;
  data_t                rd_data;
  lane_addr_t           lane_addr;
  lane_data_t           lane_data;

  assign lane_mask  = count_mask(count_q);
  assign in_collect = (state_q == S_COLLECT);
  assign timeout    = in_collect && (count_q != '0) && (tmo_q >= TMO_MAX);
  assign type_ok    = (count_q == '0) || (cli.req_rdwr == batch_type_q);
  assign cli.req_ready = in_collect && (count_q < FULL) && type_ok && !cli.flush && !timeout;
  assign accept     = cli.req_valid && cli.req_ready;

  // An opposite-type request closes the current batch so types never mix.
  assign go_issue = in_collect && (count_q != '0) &&
                    ((count_q == FULL) || cli.flush || timeout ||
                     (cli.req_valid && (cli.req_rdwr != batch_type_q)));

  assign gap_ok     = (gap_q >= GAP_MAX);
  assign issue_fire = (state_q == S_ISSUE) && gap_ok;
  assign rd_cap     = (state_q == S_WAIT_RD) && (dram_valid != '0);
  assign wr_fin     = (state_q == S_WAIT_WR) && (wait_q == WR_LAST);
  assign rsp_fire   = (state_q == S_DRAIN) && cli.rsp_ready;
  assign last_rsp   = ({1'b0, rd_idx_q} == (count_q - 1'b1));

  assign dram_en       = issue_fire ? lane_mask : '0;
  assign dram_rdwr     = batch_type_q;
  assign cli.rsp_valid = (state_q == S_DRAIN);
  assign cli.rsp_data  = (state_q == S_DRAIN) ? rd_data : '0;
  assign cli.wr_done   = wr_fin;

  always_comb begin
    dram_addr    = '0;
    dram_data_in = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      if (lane_mask[i]) begin
        dram_addr[i]    = lane_addr[i];
        dram_data_in[i] = lane_data[i];
      end
    end
  end

  dram_lane_buf u_lanes (
    .clk       (clk),
    .wr_en     (accept),
    .wr_idx    (count_q[LANE_IDX_W-1:0]),
    .wr_addr   (cli.req_addr),
    .wr_data   (cli.req_wdata),
    .ld_mask   (rd_cap ? lane_mask : '0),
    .ld_data   (dram_data_out),
    .rd_idx    (rd_idx_q),
    .rd_data   (rd_data),
    .lane_addr (lane_addr),
    .lane_data (lane_data)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_COLLECT;
      count_q      <= '0;
      batch_type_q <= 1'b1;
      tmo_q        <= '0;
      gap_q        <= GAP_MAX;
      wait_q       <= '0;
      rd_idx_q     <= '0;
    end else begin
      if (issue_fire)   gap_q <= '0;
      else if (!gap_ok) gap_q <= gap_q + 1'b1;

      case (state_q)
        S_COLLECT: begin
          if (accept) begin
            if (count_q == '0) batch_type_q <= cli.req_rdwr;
            count_q <= count_q + 1'b1;
            tmo_q   <= '0;
          end else if (go_issue) begin
            state_q <= S_ISSUE;
            tmo_q   <= '0;
          end else if ((count_q != '0) && !timeout) begin
            tmo_q <= tmo_q + 1'b1;
          end
        end
        S_ISSUE: begin
          if (issue_fire) begin
            state_q <= batch_type_q ? S_WAIT_RD : S_WAIT_WR;
            wait_q  <= '0;
          end
        end
        S_WAIT_RD: begin
          if (rd_cap) begin
            state_q  <= S_DRAIN;
            rd_idx_q <= '0;
          end
        end
        S_WAIT_WR: begin
          if (wr_fin) begin
            state_q <= S_COLLECT;
            count_q <= '0;
          end else begin
            wait_q <= wait_q + 1'b1;
          end
        end
        S_DRAIN: begin
          if (rsp_fire) begin
            if (last_rsp) begin
              state_q <= S_COLLECT;
              count_q <= '0;
            end else begin
              rd_idx_q <= rd_idx_q + 1'b1;
            end
          end
        end
        default: state_q <= S_COLLECT;
      endcase
    end
  end

endmodule

// File: tb/tb_dram_batcher.sv
// tb/tb_dram_batcher.sv - directed bench for dram_batcher with a behavioural DRAM behind it
module tb_dram_batcher;
  import dram_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  dram_batcher_if c ();

  logic [NUM_LANES-1:0] dram_en;
  logic                 dram_rdwr;
  lane_addr_t           dram_addr;
  lane_data_t           dram_data_in;
  lane_data_t           dram_data_out = '0;
  logic [NUM_LANES-1:0] dram_valid = '0;

  dram_batcher dut (
    .clk           (clk),
    .reset         (reset),
    .cli           (c),
    .dram_en       (dram_en),
    .dram_rdwr     (dram_rdwr),
    .dram_addr     (dram_addr),
    .dram_data_in  (dram_data_in),
    .dram_data_out (dram_data_out),
    .dram_valid    (dram_valid)
  );

  // Behavioural DRAM: writes commit on dram_en in lane order (highest lane
  // wins), reads return DRAM_WAIT_CYCLES later with a one-cycle valid pulse.
  logic [7:0]           mem [0:255];
  int                   pend = 0;
  logic [NUM_LANES-1:0] pend_en = '0;
  lane_addr_t           pend_addr = '0;

  initial for (int i = 0; i < 256; i++) mem[i] = 8'h00;

  always @(posedge clk) begin
    dram_valid <= '0;
    if (reset) begin
      pend          <= 0;
      dram_data_out <= '0;
    end else if (dram_en != '0) begin
      if (!dram_rdwr) begin
        for (int i = 0; i < NUM_LANES; i++)
          if (dram_en[i]) mem[dram_addr[i][7:0]] <= dram_data_in[i];
      end else begin
        pend      <= DRAM_WAIT_CYCLES;
        pend_en   <= dram_en;
        pend_addr <= dram_addr;
      end
    end else if (pend > 0) begin
      if (pend == 1) begin
        dram_valid <= pend_en;
        for (int i = 0; i < NUM_LANES; i++)
          dram_data_out[i] <= pend_en[i] ? mem[pend_addr[i][7:0]] : 8'h00;
      end
      pend <= pend - 1;
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int failed = 0;
  int issue_cyc = 0;
  int accept_cyc = 0;
  int w_issue = 0;
  int bad = 0;
  logic [63:0] issue_din = '0;
  logic [63:0] issue_a7 = '0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // All tasks start at a negedge and return at a later negedge.
  task automatic send(input logic rw, input logic [63:0] a, input logic [7:0] d);
    int n = 0;
    c.req_valid = 1'b1;
    c.req_rdwr  = rw;
    c.req_addr  = a;
    c.req_wdata = d;
    #1;
    while (!c.req_ready && n < 100) begin @(negedge clk); #1; n++; end
    check("send_ready", c.req_ready, 1);
    accept_cyc = cyc;
    @(negedge clk);
    c.req_valid = 1'b0;
  endtask

  task automatic wait_issue(input logic [7:0] en, input logic rw);
    int n = 0;
    #1;
    while (dram_en == '0 && n < 300) begin @(negedge clk); #1; n++; end
    check("issue_en", dram_en, en);
    check("issue_rdwr", dram_rdwr, rw);
    issue_cyc = cyc;
    issue_din = dram_data_in;
    issue_a7  = dram_addr[7];
    @(negedge clk);
  endtask

  task automatic wait_wr_done(input int delay);
    int n = 0;
    while (!c.wr_done && n < 100) begin @(negedge clk); n++; end
    check("wr_done_delay", cyc - issue_cyc, delay);
    check("wr_rdwr_stable", dram_rdwr, 0);
    @(negedge clk);
    check("wr_done_one_cycle", c.wr_done, 0);
  endtask

  task automatic get_rsp(input logic [7:0] d);
    int n = 0;
    #1;
    while (!c.rsp_valid && n < 200) begin @(negedge clk); #1; n++; end
    check("rsp_valid", c.rsp_valid, 1);
    check("rsp_data", c.rsp_data, d);
    @(negedge clk);
  endtask

  initial begin
    c.req_valid = 1'b0;
    c.req_rdwr  = 1'b0;
    c.req_addr  = '0;
    c.req_wdata = '0;
    c.flush     = 1'b0;
    c.rsp_ready = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    check("rst_req_ready", c.req_ready, 1);
    check("rst_rsp_valid", c.rsp_valid, 0);
    check("rst_wr_done", c.wr_done, 0);
    check("rst_dram_en", dram_en, 0);
    check("rst_dram_rdwr", dram_rdwr, 1);
    check("rst_dram_addr_zero", dram_addr == '0, 1);
    check("rst_dram_data_in", dram_data_in, 0);
    check("rst_rsp_data", c.rsp_data, 0);
    @(negedge clk);

    // Full write batch
    for (int i = 0; i < 8; i++) send(1'b0, 64'(i), 8'(8'h10 + i));
    wait_issue(8'hFF, 1'b0);
    check("wr_batch_data", issue_din, 64'h1716151413121110);
    check("wr_batch_addr7", issue_a7, 64'd7);
    wait_wr_done(22);

    // Full read batch with a 3-cycle response stall after the third byte
    for (int i = 0; i < 8; i++) send(1'b1, 64'(i), 8'h00);
    wait_issue(8'hFF, 1'b1);
    get_rsp(8'h10);
    get_rsp(8'h11);
    get_rsp(8'h12);
    c.rsp_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      check("stall_valid", c.rsp_valid, 1);
      check("stall_data", c.rsp_data, 8'h13);
      @(negedge clk);
    end
    c.rsp_ready = 1'b1;
    for (int i = 3; i < 8; i++) get_rsp(8'(8'h10 + i));
    #1;
    check("full_rd_done", c.rsp_valid, 0);
    @(negedge clk);

    // Partial read batch forced out by the idle timeout
    for (int i = 0; i < 3; i++) send(1'b1, 64'(i), 8'h00);
    w_issue = accept_cyc;
    wait_issue(8'h07, 1'b1);
    check("timeout_latency", issue_cyc - w_issue, 10);
    for (int i = 0; i < 3; i++) get_rsp(8'(8'h10 + i));
    bad = 0;
    for (int k = 0; k < 5; k++) begin #1; if (c.rsp_valid) bad++; @(negedge clk); end
    check("exactly_3_rsp", bad, 0);

    // Write batch cut short by a read
    send(1'b0, 64'd0, 8'h20);
    send(1'b0, 64'd1, 8'h21);
    c.req_valid = 1'b1;
    c.req_rdwr  = 1'b1;
    c.req_addr  = 64'd0;
    #1;
    check("mixed_ready_low", c.req_ready, 0);
    @(negedge clk);
    wait_issue(8'h03, 1'b0);
    w_issue = issue_cyc;
    send(1'b1, 64'd0, 8'h00);
    wait_issue(8'h01, 1'b1);
    check("read_after_gap", (issue_cyc - w_issue) >= 22, 1);
    get_rsp(8'h20);

    // Duplicate address in one write batch, flushed
    send(1'b0, 64'd5, 8'hAA);
    send(1'b0, 64'd5, 8'hBB);
    c.flush = 1'b1;
    wait_issue(8'h03, 1'b0);
    c.flush = 1'b0;
    wait_wr_done(22);
    send(1'b1, 64'd5, 8'h00);
    c.flush = 1'b1;
    wait_issue(8'h01, 1'b1);
    c.flush = 1'b0;
    get_rsp(8'hBB);

    // Reset during WAIT_RD
    for (int i = 0; i < 4; i++) send(1'b1, 64'(i), 8'h00);
    c.flush = 1'b1;
    wait_issue(8'h0F, 1'b1);
    c.flush = 1'b0;
    repeat (5) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("mid_rst_req_ready", c.req_ready, 1);
    check("mid_rst_rsp_valid", c.rsp_valid, 0);
    check("mid_rst_dram_en", dram_en, 0);
    check("mid_rst_rdwr", dram_rdwr, 1);
    @(negedge clk);
    bad = 0;
    for (int k = 0; k < 30; k++) begin #1; if (c.rsp_valid) bad++; @(negedge clk); end
    check("no_rsp_after_rst", bad, 0);
    send(1'b1, 64'd6, 8'h00);
    send(1'b1, 64'd7, 8'h00);
    c.flush = 1'b1;
    wait_issue(8'h03, 1'b1);
    c.flush = 1'b0;
    get_rsp(8'h16);
    get_rsp(8'h17);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
